// File: rtl/unpacked_window_pkg.sv
// Shared types and index helpers for the unpacked window shift line.
package unpacked_window_pkg;

  typedef logic signed [31:0] idx_t;

  function automatic int win_size(input int depth, input int offset);
    return depth - offset;
  endfunction

  function automatic idx_t phys_off(input idx_t idx, input idx_t origin);
    return idx - origin;
  endfunction

endpackage

// File: rtl/uwin_valid_tracker.sv
// Per-slot valid shift vector with saturating occupancy count for one window lane.
module uwin_valid_tracker #(
  parameter int WIN = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  logic          clear,
  output logic          hi_vld,
  output logic [CW-1:0] fill_cnt,
  output logic          full
);

  localparam logic [CW-1:0] WIN_C = CW'(WIN);

  logic [WIN-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      fill_cnt <= '0;
    end else if (clear) begin
      vld      <= '0;
      fill_cnt <= '0;
    end else if (shift_en) begin
      vld <= {vld[WIN-2:0], 1'b1};
      if (fill_cnt < WIN_C) fill_cnt <= fill_cnt + CW'(1);
    end
  end

  assign hi_vld = vld[WIN-1];
  assign full   = (fill_cnt == WIN_C);

endmodule

// File: rtl/unpacked_window_shifter.sv
// Shift line on an unpacked array with arbitrary signed origin; data enters at ORIGIN+OFFSET
// and exits at the high index, with a combinational absolute-index tap.
module unpacked_window_shifter
  import unpacked_window_pkg::*;
#(
  parameter int ORIGIN    = 0,
  parameter int DEPTH     = 7,
  parameter int OFFSET    = 3,
  parameter int WIDTH     = 1,
  parameter bit ASCENDING = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clear,
  input  logic [31:0]                tap_idx,
  output logic [WIDTH-1:0]           tap_data,
  output logic                       tap_oob,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_vld,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       full
);

  localparam int LO   = ORIGIN;
  localparam int HI   = ORIGIN + DEPTH - 1;
  localparam int BASE = ORIGIN + OFFSET;
  localparam int WIN  = win_size(DEPTH, OFFSET);
  localparam int CW   = $clog2(DEPTH + 1);

  idx_t             tap_s;
  idx_t             tap_off;
  logic [WIDTH-1:0] tap_raw;
  logic [WIDTH-1:0] hi_entry;
  logic             hi_vld;

  // Tap address: signed absolute index converted to a physical offset before range compare
  assign tap_s    = $signed(tap_idx);
  assign tap_off  = phys_off(tap_s, idx_t'(ORIGIN));
  assign tap_oob  = (tap_off < 0) || (tap_off > idx_t'(DEPTH - 1));
  assign tap_data = tap_oob ? '0 : tap_raw;

  generate
    if (ASCENDING) begin : g_asc
      logic [WIDTH-1:0] arr [LO:HI];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = LO; i <= HI; i++) arr[i] <= '0;
        end else if (clear) begin
          for (int i = BASE; i <= HI; i++) arr[i] <= '0;
        end else if (shift_en) begin
          arr[BASE]       <= din;
          arr[BASE+1:HI]  <= arr[BASE:HI-1];
        end
      end

      always_comb begin
        tap_raw = '0;
        for (int i = LO; i <= HI; i++)
          if (tap_s == idx_t'(i)) tap_raw = arr[i];
      end

      assign hi_entry = arr[HI];
    end else begin : g_desc
      logic [WIDTH-1:0] arr [HI:LO];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = LO; i <= HI; i++) arr[i] <= '0;
        end else if (clear) begin
          for (int i = BASE; i <= HI; i++) arr[i] <= '0;
        end else if (shift_en) begin
          arr[BASE]       <= din;
          arr[HI:BASE+1]  <= arr[HI-1:BASE];
        end
      end

      always_comb begin
        tap_raw = '0;
        for (int i = LO; i <= HI; i++)
          if (tap_s == idx_t'(i)) tap_raw = arr[i];
      end

      assign hi_entry = arr[HI];
    end
  endgenerate

  uwin_valid_tracker #(
    .WIN (WIN),
    .CW  (CW)
  ) u_valid (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clear    (clear),
    .hi_vld   (hi_vld),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

  // Output stage: dout holds between shifts, dout_vld is a one-cycle pulse per emitted element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (clear) begin
      dout_vld <= 1'b0;
    end else if (shift_en) begin
      dout     <= hi_entry;
      dout_vld <= hi_vld;
    end else begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unpacked_window_shifter.sv
// Drives one shared stimulus into fourteen shifter instances (seven origins, both array orders).
module tb_unpacked_window_shifter;

  localparam int NDUT = 14;
  localparam int WIN  = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        shift_en = 1'b0;
  logic        clear    = 1'b0;
  logic [7:0]  din      = '0;
  int          tap_rel  = 0;

  logic [31:0] tap_idx_a  [NDUT];
  logic [7:0]  tap_data_a [NDUT];
  logic        tap_oob_a  [NDUT];
  logic [7:0]  dout_a     [NDUT];
  logic        dvld_a     [NDUT];
  logic [2:0]  fc_a       [NDUT];
  logic        full_a     [NDUT];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] m_data [WIN];
  logic       m_v    [WIN];
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_dvld;

  int em [NDUT];

  function automatic int org_of(input int k);
    case (k)
      0:       return -10;
      1:       return -4;
      2:       return -1;
      3:       return 0;
      4:       return 1;
      5:       return 4;
      default: return 10;
    endcase
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int O = org_of(g / 2);
    localparam bit A = ((g % 2) == 1);
    assign tap_idx_a[g] = O + tap_rel;
    unpacked_window_shifter #(
      .ORIGIN(O), .DEPTH(7), .OFFSET(3), .WIDTH(8), .ASCENDING(A)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .din      (din),
      .clear    (clear),
      .tap_idx  (tap_idx_a[g]),
      .tap_data (tap_data_a[g]),
      .tap_oob  (tap_oob_a[g]),
      .dout     (dout_a[g]),
      .dout_vld (dvld_a[g]),
      .fill_cnt (fc_a[g]),
      .full     (full_a[g])
    );
  end

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ed, input int ev, input int ec, input int ef);
    for (int k = 0; k < NDUT; k++) begin
      check({tag, ".dout"},     k, 32'(dout_a[k]), ed);
      check({tag, ".dout_vld"}, k, 32'(dvld_a[k]), ev);
      check({tag, ".fill_cnt"}, k, 32'(fc_a[k]),   ec);
      check({tag, ".full"},     k, 32'(full_a[k]), ef);
    end
  endtask

  task automatic chk_tap(input string tag, input int rel, input int ed, input int eo);
    tap_rel = rel;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s.tap_data[%0d]", tag, rel), k, 32'(tap_data_a[k]), ed);
      check($sformatf("%s.tap_oob[%0d]", tag, rel),  k, 32'(tap_oob_a[k]),  eo);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < WIN; j++) begin
      m_data[j] = '0;
      m_v[j]    = 1'b0;
    end
    m_cnt  = 0;
    m_dout = '0;
    m_dvld = 1'b0;
  endtask

  task automatic model_step(input bit se, input bit clr, input logic [7:0] d);
    if (clr) begin
      for (int j = 0; j < WIN; j++) begin
        m_data[j] = '0;
        m_v[j]    = 1'b0;
      end
      m_cnt  = 0;
      m_dvld = 1'b0;
    end else if (se) begin
      m_dout = m_data[WIN-1];
      m_dvld = m_v[WIN-1];
      for (int j = WIN - 1; j > 0; j--) begin
        m_data[j] = m_data[j-1];
        m_v[j]    = m_v[j-1];
      end
      m_data[0] = d;
      m_v[0]    = 1'b1;
      if (m_cnt < WIN) m_cnt++;
    end else begin
      m_dvld = 1'b0;
    end
  endtask

  task automatic cyc(input bit se, input bit clr, input logic [7:0] d);
    shift_en = se;
    clear    = clr;
    din      = d;
    @(posedge clk);
    #1;
    model_step(se, clr, d);
    shift_en = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s;
    int ed;
    int rel;
    int et;
    bit se;
    bit clr;
    logic [7:0] d;

    // Scenario 1: reset state, first fill, latency to dout
    do_reset();
    chk_out("rst", 0, 0, 0, 0);
    for (int r = 0; r < 7; r++) chk_tap("rst", r, 0, 0);
    for (int f = 1; f <= 4; f++) begin
      cyc(1'b1, 1'b0, 8'h01);
      chk_out("fill", 0, 0, f, (f == 4) ? 1 : 0);
      chk_tap("fill", 3 + f - 1, 1, 0);
      if (f < 4) chk_tap("fill_next", 3 + f, 0, 0);
    end
    cyc(1'b1, 1'b0, 8'h01);
    chk_out("emit", 1, 1, 4, 1);
    cyc(1'b0, 1'b0, 8'h00);
    chk_out("hold", 1, 0, 4, 1);

    // Scenario 2: stream with shift_en toggling
    do_reset();
    for (int k = 0; k < NDUT; k++) em[k] = 0;
    s = 0;
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 0) begin
        s++;
        d = (s <= 5) ? 8'(8'h11 * s) : 8'h00;
        cyc(1'b1, 1'b0, d);
        ed = (s >= 5) ? (8'h11 * (s - 4)) : 0;
        chk_out("stream_sh", ed, (s >= 5) ? 1 : 0, (s < 4) ? s : 4, (s >= 4) ? 1 : 0);
      end else begin
        cyc(1'b0, 1'b0, 8'hEE);
        ed = (s >= 5) ? (8'h11 * (s - 4)) : 0;
        chk_out("stream_idle", ed, 0, (s < 4) ? s : 4, (s >= 4) ? 1 : 0);
      end
      for (int k = 0; k < NDUT; k++) if (dvld_a[k] === 1'b1) em[k]++;
    end
    for (int k = 0; k < NDUT; k++) check("stream_count", k, em[k], 5);

    // Scenario 3: clear wins over shift
    do_reset();
    for (int f = 1; f <= 5; f++) cyc(1'b1, 1'b0, 8'(8'hA0 + f));
    chk_out("prefill", 8'hA1, 1, 4, 1);
    cyc(1'b1, 1'b1, 8'hFF);
    chk_out("clear", 8'hA1, 0, 0, 0);
    for (int r = 3; r < 7; r++) chk_tap("clear", r, 0, 0);
    cyc(1'b1, 1'b0, 8'h5A);
    chk_out("post_clear", 0, 0, 1, 0);
    chk_tap("post_clear", 3, 8'h5A, 0);
    chk_tap("post_clear", 4, 0, 0);

    // Scenario 4: tap range boundaries after traffic
    chk_tap("oob", -1, 0, 1);
    chk_tap("oob", 7, 0, 1);
    chk_tap("oob", -1000, 0, 1);
    chk_tap("oob", 1000, 0, 1);
    chk_tap("low", 0, 0, 0);
    chk_tap("low", 1, 0, 0);
    chk_tap("low", 2, 0, 0);
    chk_tap("hi", 6, 0, 0);

    // Scenario 5: asynchronous reset mid-cycle
    do_reset();
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b1, 1'b0, 8'h78);
    chk_out("pre_arst", 0, 0, 2, 0);
    chk_tap("pre_arst", 4, 8'h77, 0);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("arst", 0, 0, 0, 0);
    chk_tap("arst", 3, 0, 0);
    chk_tap("arst", 4, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 1; f <= 3; f++) cyc(1'b1, 1'b0, 8'(8'h30 + f));
    chk_out("refill3", 0, 0, 3, 0);
    cyc(1'b1, 1'b0, 8'h34);
    chk_out("refill4", 0, 0, 4, 1);
    chk_tap("refill4", 6, 8'h31, 0);

    // Scenario 6: random traffic against the reference model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      se  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      d   = 8'($urandom);
      cyc(se, clr, d);
      chk_out("rand", m_dout, m_dvld, m_cnt, (m_cnt == WIN) ? 1 : 0);
      rel = $urandom_range(0, 6);
      et  = (rel < 3) ? 0 : m_data[rel-3];
      chk_tap("rand", rel, et, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
